// File: rtl/aes_key_bank.sv
// AES round-key bank: 11 x 128-bit slots, loaded strictly in order by one-hot writes, read by round index.
// Define AES_KEY_BANK_ZEROIZE_EN to add the zeroize port and the slot-by-slot WIPE sequence.
module aes_key_bank #(
  parameter int NUM_SLOTS = 11,
  parameter int KEY_W     = 128,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_W-1:0]     key_in,
  input  logic [NUM_SLOTS-1:0] set_key_onehot,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic                 rd_inv,
  input  logic                 clr_err,
  output logic                 rd_valid,
  output logic [KEY_W-1:0]     rd_data,
  output logic                 keys_ready,
  output logic                 load_err,
  output logic                 busy
`ifdef AES_KEY_BANK_ZEROIZE_EN
  , input logic                zeroize
`endif
);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [NUM_SLOTS-1:0] ONE      = NUM_SLOTS'(1);

  typedef enum logic [2:0] {
    S_EMPTY, S_LOADING, S_READY, S_ERROR
`ifdef AES_KEY_BANK_ZEROIZE_EN
    , S_WIPE
`endif
  } state_e;

  state_e                          state_q, state_d;
  logic   [IDX_W-1:0]              exp_q, exp_d;
  logic   [NUM_SLOTS-1:0]          wr_vec, clr_vec;
  logic   [NUM_SLOTS-1:0][KEY_W-1:0] slot_q;
  logic   [IDX_W-1:0]              rd_sel;
  logic                            rd_ok;
`ifdef AES_KEY_BANK_ZEROIZE_EN
  logic   [IDX_W-1:0]              wipe_q, wipe_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      exp_q   <= '0;
`ifdef AES_KEY_BANK_ZEROIZE_EN
      wipe_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
`ifdef AES_KEY_BANK_ZEROIZE_EN
      wipe_q  <= wipe_d;
`endif
    end
  end

  // zeroize > wipe progress > clr_err > key patterns
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    wr_vec  = '0;
    clr_vec = '0;
`ifdef AES_KEY_BANK_ZEROIZE_EN
    wipe_d  = wipe_q;
    if (zeroize) begin
      state_d = S_WIPE;
      wipe_d  = '0;
    end else if (state_q == S_WIPE) begin
      clr_vec = ONE << wipe_q;
      wipe_d  = wipe_q + 1'b1;
      if (wipe_q == LAST_IDX) begin
        state_d = S_EMPTY;
        exp_d   = '0;
      end
    end else
`endif
    if (clr_err) begin
      state_d = S_EMPTY;
      exp_d   = '0;
    end else if (set_key_onehot != '0) begin
      case (state_q)
        S_EMPTY, S_READY: begin
          if (set_key_onehot == ONE) begin
            wr_vec  = ONE;
            exp_d   = IDX_W'(1);
            state_d = S_LOADING;
          end else begin
            state_d = S_ERROR;
          end
        end
        S_LOADING: begin
          if (set_key_onehot == ONE) begin
            wr_vec = ONE;
            exp_d  = IDX_W'(1);
          end else if (set_key_onehot == (ONE << exp_q)) begin
            wr_vec = set_key_onehot;
            exp_d  = exp_q + 1'b1;
            if (exp_q == LAST_IDX) state_d = S_READY;
          end else begin
            state_d = S_ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          slot_q[i] <= '0;
      else if (clr_vec[i]) slot_q[i] <= '0;
      else if (wr_vec[i])  slot_q[i] <= key_in;
    end
  end

  // Reads sample the slots before this edge's write, so same-slot read returns the old key.
  assign rd_sel = rd_inv ? (LAST_IDX - rd_idx) : rd_idx;
  assign rd_ok  = (rd_idx <= LAST_IDX) && (state_q == S_READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= (rd_en && rd_ok) ? slot_q[rd_sel] : '0;
    end
  end

  assign keys_ready = (state_q == S_READY);
  assign load_err   = (state_q == S_ERROR);
`ifdef AES_KEY_BANK_ZEROIZE_EN
  assign busy       = (state_q == S_LOADING) || (state_q == S_WIPE);
`else
  assign busy       = (state_q == S_LOADING);
`endif

endmodule

// File: tb/tb_aes_key_bank.sv
// Directed bench for aes_key_bank: per-cycle compare against a slot/mode model plus literal spot checks.
module tb_aes_key_bank;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic [10:0]  set_key_onehot = '0;
  logic         rd_en = 1'b0, rd_inv = 1'b0, clr_err = 1'b0, zer = 1'b0;
  logic [3:0]   rd_idx = '0;
  logic         rd_valid, keys_ready, load_err, busy;
  logic [127:0] rd_data;

  aes_key_bank dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .set_key_onehot(set_key_onehot),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_inv(rd_inv), .clr_err(clr_err),
    .rd_valid(rd_valid), .rd_data(rd_data), .keys_ready(keys_ready),
    .load_err(load_err), .busy(busy)
`ifdef AES_KEY_BANK_ZEROIZE_EN
    , .zeroize(zer)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0, nbad = 0;
  bit run = 1'b0;

  localparam int M_EMPTY = 0, M_LOAD = 1, M_READY = 2, M_ERR = 3, M_WIPE = 4;
  logic [127:0] m_slot [11];
  int           m_mode, m_next, m_wcnt;
  logic         m_rv;
  logic [127:0] m_rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] kgen(input int i, input logic [7:0] salt);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = 8'(16*i + j) ^ salt;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 11; i++) m_slot[i] = '0;
    m_mode = M_EMPTY; m_next = 0; m_wcnt = 0; m_rv = 1'b0; m_rd = '0;
  endtask

  // One clock edge of the spec's rules, using the inputs that were present at that edge.
  task automatic model_edge();
    int tgt, sel;
    if (!rst_n) begin model_reset(); return; end
    m_rv = rd_en;
    m_rd = '0;
    if (rd_en && rd_idx <= 10 && m_mode == M_READY) begin
      sel  = rd_inv ? 10 - int'(rd_idx) : int'(rd_idx);
      m_rd = m_slot[sel];
    end
    if (zer) begin
      m_mode = M_WIPE; m_wcnt = 0;
    end else if (m_mode == M_WIPE) begin
      m_slot[m_wcnt] = '0;
      m_wcnt++;
      if (m_wcnt == 11) m_mode = M_EMPTY;
    end else if (clr_err) begin
      m_mode = M_EMPTY;
    end else if (set_key_onehot != 0 && m_mode != M_ERR) begin
      if ($countones(set_key_onehot) != 1) m_mode = M_ERR;
      else begin
        tgt = 0;
        for (int b = 0; b < 11; b++) if (set_key_onehot[b]) tgt = b;
        if (tgt == 0) begin
          m_slot[0] = key_in; m_next = 1; m_mode = M_LOAD;
        end else if (m_mode == M_LOAD && tgt == m_next) begin
          m_slot[tgt] = key_in; m_next++;
          if (tgt == 10) m_mode = M_READY;
        end else m_mode = M_ERR;
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_rd_valid", 128'(rd_valid), 128'(m_rv));
      chk("cyc_rd_data", rd_data, m_rd);
      chk("cyc_keys_ready", 128'(keys_ready), 128'(m_mode == M_READY));
      chk("cyc_load_err", 128'(load_err), 128'(m_mode == M_ERR));
      chk("cyc_busy", 128'(busy), 128'(m_mode == M_LOAD || m_mode == M_WIPE));
    end
  end

  task automatic step(input logic [10:0] s = '0, input logic [127:0] k = '0, input logic re = 1'b0,
                      input logic [3:0] ri = '0, input logic inv = 1'b0, input logic c = 1'b0);
    set_key_onehot = s; key_in = k; rd_en = re; rd_idx = ri; rd_inv = inv; clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
    set_key_onehot = '0; key_in = '0; rd_en = 1'b0; rd_idx = '0; rd_inv = 1'b0; clr_err = 1'b0;
  endtask

  task automatic read_sweep();
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1'b1, 4'(i), 1'b0);
      step(0, 0, 1'b1, 4'(i), 1'b1);
    end
  endtask

  initial begin
    model_reset();
    run = 1'b1;
    step(); step();
    chk("reset_rd_valid", 128'(rd_valid), 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_keys_ready", 128'(keys_ready), 0);
    chk("reset_load_err", 128'(load_err), 0);
    chk("reset_busy", 128'(busy), 0);
    rst_n = 1'b1;

    // read before any load
    step(0, 0, 1'b1, 4'd0);
    chk("early_rd_valid", 128'(rd_valid), 1);
    chk("early_rd_data", rd_data, 0);

    // back-to-back full load
    for (int i = 0; i < 11; i++) step(11'(1 << i), kgen(i, 8'h00));
    chk("full_keys_ready", 128'(keys_ready), 1);
    chk("full_busy", 128'(busy), 0);
    step(0, 0, 1'b1, 4'd3, 1'b0);
    chk("rd3_fwd", rd_data, 128'h303132333435363738393a3b3c3d3e3f);
    step(0, 0, 1'b1, 4'd3, 1'b1);
    chk("rd3_inv", rd_data, 128'h707172737475767778797a7b7c7d7e7f);
    step(0, 0, 1'b1, 4'd11, 1'b0);
    chk("rd11_valid", 128'(rd_valid), 1);
    chk("rd11_data", rd_data, 0);
    step(0, 0, 1'b1, 4'd15, 1'b1);
    chk("rd15_data", rd_data, 0);
    read_sweep();

    // reload from READY with a same-cycle read of slot 0
    step(11'h001, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b1, 4'd0);
    chk("reload_old_k0", rd_data, 128'h000102030405060708090a0b0c0d0e0f);
    chk("reload_keys_ready", 128'(keys_ready), 0);

    // gap then out-of-order
    step(11'h001, kgen(0, 8'h11)); step(); step(11'h002, kgen(1, 8'h11)); step(11'h008, kgen(3, 8'h11));
    chk("ooo_load_err", 128'(load_err), 1);
    step(11'h001, kgen(0, 8'h22));
    chk("err_ignores", 128'(busy), 0);
    step(0, 0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("clr_load_err", 128'(load_err), 0);

    // multi-hot, then clr_err beating a slot-0 pattern
    step(11'h003, kgen(5, 8'h33));
    chk("multihot_err", 128'(load_err), 1);
    step(11'h001, kgen(0, 8'h44), 1'b0, 4'd0, 1'b0, 1'b1);
    chk("clr_prio_busy", 128'(busy), 0);
    chk("clr_prio_err", 128'(load_err), 0);
    step(11'h002, kgen(1, 8'h44));
    chk("empty_bit1_err", 128'(load_err), 1);
    step(0, 0, 1'b0, 4'd0, 1'b0, 1'b1);

    // reset pulsed mid-load
    for (int i = 0; i < 4; i++) step(11'(1 << i), kgen(i, 8'h55));
    step(11'h010, kgen(4, 8'h55), 1'b1, 4'd4);
    rst_n = 1'b0; model_reset(); #1;
    chk("midrst_rd_valid", 128'(rd_valid), 0);
    chk("midrst_busy", 128'(busy), 0);
    step();
    rst_n = 1'b1;
    step(11'h002, kgen(1, 8'h66));
    chk("postrst_empty", 128'(load_err), 1);
    step(0, 0, 1'b0, 4'd0, 1'b0, 1'b1);

    // load with gaps, then read everything
    for (int i = 0; i < 11; i++) begin
      step(11'(1 << i), kgen(i, 8'ha5));
      if (i % 3 == 0) step();
    end
    chk("gap_keys_ready", 128'(keys_ready), 1);
    read_sweep();

`ifdef AES_KEY_BANK_ZEROIZE_EN
    begin
      int n = 0;
      zer = 1'b1; step(11'h001, kgen(0, 8'h77)); zer = 1'b0;
      chk("wipe_busy", 128'(busy), 1);
      for (int i = 0; i < 4; i++) step(11'h001, kgen(0, 8'h77));
      zer = 1'b1; step(); zer = 1'b0;
      while (busy && n < 30) begin step(0, 0, 1'b1, 4'(n % 11)); n++; end
      chk("wipe_len", 128'(n), 11);
      chk("wipe_err", 128'(load_err), 0);
      for (int i = 0; i < 11; i++) step(11'(1 << i), (i == 0) ? kgen(0, 8'h99) : 128'h0);
      step(0, 0, 1'b1, 4'd10, 1'b1);
      chk("wipe_reload_k0", rd_data, kgen(0, 8'h99));
      read_sweep();
    end
`endif

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
